// File: rtl/pbit_sample_collector_pkg.sv
// Shared types and default widths for the p-bit sample collector.
package pbit_sample_collector_pkg;

  localparam int unsigned N_BITS_DEF     = 5;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned BURN_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BURN = 2'd1,
    ST_ACC  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/pbit_sample_collector_if.sv
// Run control, sample stream and result handshake of the p-bit sample collector.
interface pbit_sample_collector_if #(
  parameter int unsigned N_BITS     = pbit_sample_collector_pkg::N_BITS_DEF,
  parameter int unsigned CNT_WIDTH  = pbit_sample_collector_pkg::CNT_WIDTH_DEF,
  parameter int unsigned BURN_WIDTH = pbit_sample_collector_pkg::BURN_WIDTH_DEF
) ();

  logic                          start;
  logic                          abort;
  logic [CNT_WIDTH-1:0]          window;
  logic [BURN_WIDTH-1:0]         burn_in;
  logic                          sample_en;
  logic [N_BITS-1:0]             p_bits;
  logic                          busy;
  logic                          res_valid;
  logic                          res_ready;
  logic [N_BITS*CNT_WIDTH-1:0]   ones_count;
  logic [N_BITS-1:0]             majority;

  modport master (
    output start, abort, window, burn_in, sample_en, p_bits, res_ready,
    input  busy, res_valid, ones_count, majority
  );

  modport slave (
    input  start, abort, window, burn_in, sample_en, p_bits, res_ready,
    output busy, res_valid, ones_count, majority
  );

endinterface

// File: rtl/pbit_sample_collector_ones_counter.sv
// Single-bit ones accumulator with a majority flag captured on result entry.
module pbit_ones_counter
  import pbit_sample_collector_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  input  logic                 maj_en_i,
  input  logic [CNT_WIDTH-1:0] window_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 maj_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 maj_q, maj_d;

  // Majority sees the count including the sample taken on the same edge.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && bit_i) begin
      count_d = count_q + CNT_WIDTH'(1);
    end

    maj_d = maj_q;
    if (maj_en_i) begin
      maj_d = ({count_d, 1'b0} > {1'b0, window_i});
    end else if (clr_i) begin
      maj_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      maj_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      maj_q   <= maj_d;
    end
  end

  assign count_o = count_q;
  assign maj_o   = maj_q;

endmodule

// File: rtl/pbit_sample_collector.sv
// Burn-in, windowed ones counting and majority readout for a p-bit vector.
module pbit_sample_collector
  import pbit_sample_collector_pkg::*;
#(
  parameter int unsigned N_BITS     = N_BITS_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned BURN_WIDTH = BURN_WIDTH_DEF
) (
  input logic                    clk,
  input logic                    reset,
  pbit_sample_collector_if.slave bus
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  win_q, win_d;
  logic [CNT_WIDTH-1:0]  samp_q, samp_d;
  logic [BURN_WIDTH-1:0] burn_q, burn_d;
  logic [BURN_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                  busy_q, valid_q;
  logic                  clr_c, acc_en_c, maj_en_c;

  // Next state; abort overrides every transition including a start in IDLE.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    burn_d   = burn_q;
    bcnt_d   = bcnt_q;
    samp_d   = samp_q;
    clr_c    = 1'b0;
    acc_en_c = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
      bcnt_d  = '0;
      samp_d  = '0;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            win_d  = bus.window;
            burn_d = bus.burn_in;
            bcnt_d = '0;
            samp_d = '0;
            clr_c  = 1'b1;
            if (bus.burn_in != '0)     state_d = ST_BURN;
            else if (bus.window != '0) state_d = ST_ACC;
            else                       state_d = ST_HOLD;
          end
        end
        ST_BURN: begin
          if (bus.sample_en) begin
            bcnt_d = bcnt_q + BURN_WIDTH'(1);
            if (bcnt_q == burn_q - BURN_WIDTH'(1)) begin
              state_d = (win_q != '0) ? ST_ACC : ST_HOLD;
            end
          end
        end
        ST_ACC: begin
          if (bus.sample_en) begin
            acc_en_c = 1'b1;
            samp_d   = samp_q + CNT_WIDTH'(1);
            if (samp_q == win_q - CNT_WIDTH'(1)) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    maj_en_c = (state_d == ST_HOLD) && (state_q != ST_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      burn_q  <= '0;
      bcnt_q  <= '0;
      samp_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      burn_q  <= burn_d;
      bcnt_q  <= bcnt_d;
      samp_q  <= samp_d;
      busy_q  <= (state_d == ST_BURN) || (state_d == ST_ACC);
      valid_q <= (state_d == ST_HOLD);
    end
  end

  logic [N_BITS*CNT_WIDTH-1:0] cnt_c;
  logic [N_BITS-1:0]           maj_c;

  for (genvar g = 0; g < int'(N_BITS); g++) begin : g_bit
    pbit_ones_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk      (clk),
      .rst_n    (reset),
      .clr_i    (clr_c),
      .en_i     (acc_en_c),
      .bit_i    (bus.p_bits[g]),
      .maj_en_i (maj_en_c),
      .window_i (win_d),
      .count_o  (cnt_c[g*CNT_WIDTH +: CNT_WIDTH]),
      .maj_o    (maj_c[g])
    );
  end

  assign bus.busy       = busy_q;
  assign bus.res_valid  = valid_q;
  assign bus.ones_count = cnt_c;
  assign bus.majority   = maj_c;

endmodule
